// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl
// Purpose: glue between the UART receive shifter, an 8-deep FWFT RX FIFO and
// the APB register block. Completed frames are registered and written into
// the FIFO one cycle later. APB reads of the RX data register pop the FIFO
// and return the head word. The block also tracks FIFO occupancy, flushes
// the FIFO on request, and raises the threshold, timeout and overrun flags.
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   rx_en, rx_done, rx_frame frame input from the receiver ({ferr, perr, data})
//   char_tick                one pulse per character time, drives the timeout
//   flush                    discard the FIFO contents
//   trig_level               threshold level, 0 disables irq_thr
//   ovr_clr                  clears the sticky ovr and rd_underflow flags
//   rd_req / rd_ack          APB read request and data-valid strobe
//   rd_data/rd_perr/rd_ferr  popped word, valid with rd_ack
//   fifo_wr/fifo_din         FIFO write side
//   fifo_rd/fifo_dout        FIFO pop side (head word shown before the pop)
//   fifo_full/fifo_empty     FIFO status flags
//   fifo_rst_n               active-low FIFO clear, held low while flushing
//   level                    FIFO occupancy 0..8
//   irq_thr/irq_to/ovr/rd_underflow  interrupt and status flags
module uart_rx_fifo_ctrl #(
  parameter int DATA_WIDTH    = 10,
  parameter int POINTER_WIDTH = 3,
  parameter int TIMEOUT_CHARS = 4,
  parameter int TO_WIDTH      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_en,
  input  logic                     rx_done,
  input  logic [DATA_WIDTH-1:0]    rx_frame,
  input  logic                     char_tick,
  input  logic                     flush,
  input  logic [POINTER_WIDTH:0]   trig_level,
  input  logic                     ovr_clr,
  input  logic                     rd_req,
  output logic                     rd_ack,
  output logic [7:0]               rd_data,
  output logic                     rd_perr,
  output logic                     rd_ferr,
  output logic                     fifo_wr,
  output logic [DATA_WIDTH-1:0]    fifo_din,
  output logic                     fifo_rd,
  input  logic [DATA_WIDTH-1:0]    fifo_dout,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  output logic                     fifo_rst_n,
  output logic [POINTER_WIDTH:0]   level,
  output logic                     irq_thr,
  output logic                     irq_to,
  output logic                     ovr,
  output logic                     rd_underflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] POP   = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  localparam logic [POINTER_WIDTH:0] DEPTH   = {1'b1, {POINTER_WIDTH{1'b0}}};
  localparam logic [POINTER_WIDTH:0] LVL_ONE = {{POINTER_WIDTH{1'b0}}, 1'b1};
  localparam logic [TO_WIDTH-1:0]    TO_MAX  = TO_WIDTH'(TIMEOUT_CHARS);
  localparam logic [TO_WIDTH-1:0]    TO_ONE  = {{(TO_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]               state_q, state_d;
  logic                     flush_cnt_q, flush_cnt_d;
  logic                     wr_pend_q, wr_pend_d;
  logic [DATA_WIDTH-1:0]    din_q, din_d;
  logic [POINTER_WIDTH:0]   level_q, level_d;
  logic [TO_WIDTH-1:0]      to_cnt_q, to_cnt_d;
  logic                     irq_thr_q, irq_thr_d;
  logic                     irq_to_q, irq_to_d;
  logic                     ovr_q, ovr_d;
  logic                     udf_q, udf_d;
  logic [7:0]               rd_data_q, rd_data_d;
  logic                     rd_perr_q, rd_perr_d;
  logic                     rd_ferr_q, rd_ferr_d;

  logic flushing;
  logic accept;
  logic wr_blocked;
  logic empty_read;

  // A flush request takes effect in the cycle it arrives, so writes, pops
  // and acks that would otherwise happen in that cycle are suppressed.
  assign flushing   = flush | (state_q == FLUSH);
  assign accept     = rx_done & rx_en & ~flushing;
  assign fifo_wr    = wr_pend_q & ~fifo_full & ~flush;
  assign wr_blocked = wr_pend_q & fifo_full & ~flush;
  assign fifo_rd    = (state_q == POP) & ~flush;
  assign rd_ack     = (state_q == ACK) & ~flush;
  assign empty_read = (state_q == IDLE) & rd_req & fifo_empty & ~flush;
  assign fifo_rst_n = (state_q != FLUSH);

  assign fifo_din     = din_q;
  assign level        = level_q;
  assign irq_thr      = irq_thr_q;
  assign irq_to       = irq_to_q;
  assign ovr          = ovr_q;
  assign rd_underflow = udf_q;
  assign rd_data      = rd_data_q;
  assign rd_perr      = rd_perr_q;
  assign rd_ferr      = rd_ferr_q;

  // Read sequencer. A read of an empty FIFO skips POP and acks with zeros.
  // FLUSH always lasts two cycles; a new flush pulse restarts it.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      state_d     = FLUSH;
      flush_cnt_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (rd_req) state_d = fifo_empty ? ACK : POP;
        POP:     state_d = ACK;
        ACK:     state_d = IDLE;
        FLUSH: begin
          if (flush_cnt_q) state_d = IDLE;
          else             flush_cnt_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Write path: the frame is held for one cycle and written only if the
  // FIFO is not full in that cycle; a blocked write is counted as overrun.
  always_comb begin
    wr_pend_d = accept;
    din_d     = accept ? rx_frame : din_q;
  end

  // Occupancy and character timeout. The timeout only runs while data is
  // waiting and nothing is moving in or out of the FIFO.
  always_comb begin
    level_d = level_q;
    if (flushing)
      level_d = '0;
    else if (fifo_wr && !fifo_rd && level_q != DEPTH)
      level_d = level_q + LVL_ONE;
    else if (fifo_rd && !fifo_wr && level_q != '0)
      level_d = level_q - LVL_ONE;

    to_cnt_d = to_cnt_q;
    if (flushing || fifo_wr || fifo_rd || level_q == '0)
      to_cnt_d = '0;
    else if (char_tick && to_cnt_q != TO_MAX)
      to_cnt_d = to_cnt_q + TO_ONE;

    irq_to_d = irq_to_q;
    if (flushing || fifo_wr || fifo_rd)
      irq_to_d = 1'b0;
    else if (to_cnt_d == TO_MAX)
      irq_to_d = 1'b1;
  end

  // Sticky flags (a new set beats a simultaneous clear), the threshold
  // interrupt, and capture of the popped word.
  always_comb begin
    irq_thr_d = rx_en & (trig_level != '0) & (level_q >= trig_level);

    ovr_d = ovr_q;
    if (wr_blocked)   ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;

    udf_d = udf_q;
    if (empty_read)   udf_d = 1'b1;
    else if (ovr_clr) udf_d = 1'b0;

    rd_data_d = rd_data_q;
    rd_perr_d = rd_perr_q;
    rd_ferr_d = rd_ferr_q;
    if (fifo_rd) begin
      rd_data_d = fifo_dout[7:0];
      rd_perr_d = fifo_dout[8];
      rd_ferr_d = fifo_dout[9];
    end else if (empty_read) begin
      rd_data_d = '0;
      rd_perr_d = 1'b0;
      rd_ferr_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      din_q       <= '0;
      level_q     <= '0;
      to_cnt_q    <= '0;
      irq_thr_q   <= 1'b0;
      irq_to_q    <= 1'b0;
      ovr_q       <= 1'b0;
      udf_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_perr_q   <= 1'b0;
      rd_ferr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wr_pend_q   <= wr_pend_d;
      din_q       <= din_d;
      level_q     <= level_d;
      to_cnt_q    <= to_cnt_d;
      irq_thr_q   <= irq_thr_d;
      irq_to_q    <= irq_to_d;
      ovr_q       <= ovr_d;
      udf_q       <= udf_d;
      rd_data_q   <= rd_data_d;
      rd_perr_q   <= rd_perr_d;
      rd_ferr_q   <= rd_ferr_d;
    end
  end

endmodule
